// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - state encoding and stop-cause codes for the cpu run controller
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CORE_RST = 2'd1,
        ST_RUN      = 2'd2,
        ST_HALT     = 2'd3
    } run_state_e;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_SELF_LOOP = 2'd1;
    localparam logic [1:0] CAUSE_STOP      = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_pc_stall_det.sv
// rtl/cpu_run_ctrl_pc_stall_det.sv - flags a run whose fetch pc has stayed put for HALT_WINDOW cycles
module pc_stall_det #(
    parameter int PC_W        = 16,
    parameter int HALT_WINDOW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic [PC_W-1:0] pc,
    output logic            loop_hit
);

    localparam int              SW      = $clog2(HALT_WINDOW);
    localparam logic [SW-1:0]   HIT_CNT = SW'(HALT_WINDOW - 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic            first_q, first_d;

    // The first enabled cycle has no valid previous pc, so it only seeds pc_q.
    always_comb begin
        pc_d     = pc_q;
        stable_d = stable_q;
        first_d  = first_q;
        loop_hit = 1'b0;
        if (clear) begin
            first_d  = 1'b1;
            stable_d = '0;
        end else if (enable) begin
            pc_d    = pc;
            first_d = 1'b0;
            if (first_q || (pc != pc_q)) begin
                stable_d = '0;
            end else if (stable_q != HIT_CNT) begin
                stable_d = stable_q + 1'b1;
            end
            loop_hit = (stable_d == HIT_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            stable_q <= '0;
            first_q  <= 1'b1;
        end else begin
            pc_q     <= pc_d;
            stable_q <= stable_d;
            first_q  <= first_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - cpu reset/run sequencer with cycle and retire counters; watchdog under CPU_RUN_CTRL_TIMEOUT_EN
module cpu_run_ctrl #(
    parameter int PC_W        = 16,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int HALT_WINDOW = 8,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [PC_W-1:0]  pc,
    input  logic             retire,
    output logic             cpu_rst,
    output logic             running,
    output logic             halted,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);
    import cpu_run_ctrl_pkg::*;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e       state_q, state_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic             loop_hit;
    logic             timeout_hit;

    pc_stall_det #(
        .PC_W        (PC_W),
        .HALT_WINDOW (HALT_WINDOW)
    ) u_pc_stall_det (
        .clk      (clk),
        .rst      (rst),
        .enable   (state_q == ST_RUN),
        .clear    (state_q != ST_RUN),
        .pc       (pc),
        .loop_hit (loop_hit)
    );

`ifdef CPU_RUN_CTRL_TIMEOUT_EN
    assign timeout_hit = (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));
`else
    logic unused_max_cycles;
    assign unused_max_cycles = (MAX_CYCLES != 0);
    assign timeout_hit       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        cause_d      = cause_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                // stop suppresses start; only an idle block records it as a cause
                if (stop) begin
                    if (state_q == ST_IDLE) begin
                        cause_d = CAUSE_STOP;
                    end
                end else if (start) begin
                    state_d      = ST_CORE_RST;
                    rst_cnt_d    = RCW'(RST_CYCLES - 1);
                    cycle_cnt_d  = '0;
                    retire_cnt_d = '0;
                    cause_d      = CAUSE_NONE;
                end
            end
            ST_CORE_RST: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_STOP;
                end else if (rst_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                if (retire && (retire_cnt_q != '1)) begin
                    retire_cnt_d = retire_cnt_q + 1'b1;
                end
                if (stop) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_STOP;
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else if (loop_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_SELF_LOOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cpu_rst_d = (state_d != ST_RUN);
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            cause_q      <= CAUSE_NONE;
            cpu_rst_q    <= 1'b1;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            cause_q      <= cause_d;
            cpu_rst_q    <= cpu_rst_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
        end
    end

    assign cpu_rst    = cpu_rst_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign cause      = cause_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule
